// File: rtl/parking_sensor_emulator.sv
// parking_sensor_emulator
//   Plays the outer/inner photo-sensor sequences that the parking lot occupancy
//   decoder expects (car enter/exit, pedestrian enter/exit). One command runs
//   at a time, and each of its four phases is held for a programmable dwell.
//
// Handshake: a command is accepted when start=1 at a rising edge while the FSM
//   is IDLE. There is no ready signal. busy=1 tells the caller that a start
//   would be discarded. A start seen while busy is not queued; it is reported
//   by a one-cycle drop pulse.
//
// Ports
//   clk    in            system clock
//   reset  in            synchronous, active-low
//   start  in            command request, sampled only in IDLE
//   cmd    in  [1:0]     00 car enter, 01 car exit, 10 ped enter, 11 ped exit
//   dwell  in  [DWELL_W] cycles per phase (0 behaves as 1)
//   outer  out           emulated outer sensor, 1 = blocked
//   inner  out           emulated inner sensor, 1 = blocked
//   busy   out           sequence in progress
//   done   out           1-cycle pulse on the last cycle of the final phase
//   drop   out           1-cycle pulse after a start that arrived while busy
//   sent   out [SENT_W]  completed-command count, wraps to 0
module parking_sensor_emulator #(
    parameter int DWELL_W = 8,
    parameter int SENT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         cmd,
    input  logic [DWELL_W-1:0] dwell,
    output logic               outer,
    output logic               inner,
    output logic               busy,
    output logic               done,
    output logic               drop,
    output logic [SENT_W-1:0]  sent
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        P4   = 3'd4
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    state_t             state_q, state_n;
    logic [DWELL_W-1:0] cnt_q, cnt_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic [1:0]         cmd_q, cmd_n;
    logic [1:0]         lines_n;
    logic               busy_n, done_n, drop_n;
    logic [SENT_W-1:0]  sent_n;

    // {outer,inner} for each command and phase.
    function automatic logic [1:0] phase_lines(input logic [1:0] c, input state_t s);
        logic [1:0] l;
        l = 2'b00;
        case (c)
            2'b00: case (s) P1: l = 2'b10; P2: l = 2'b11; P3: l = 2'b01; default: l = 2'b00; endcase
            2'b01: case (s) P1: l = 2'b01; P2: l = 2'b11; P3: l = 2'b10; default: l = 2'b00; endcase
            2'b10: case (s) P1: l = 2'b10; P2: l = 2'b00; P3: l = 2'b01; default: l = 2'b00; endcase
            default: case (s) P1: l = 2'b01; P2: l = 2'b00; P3: l = 2'b10; default: l = 2'b00; endcase
        endcase
        return l;
    endfunction

    // Next state and the registered output values are derived together. As a
    // result, the lines switch directly from one phase pattern to the next,
    // and done lines up with the final cycle of P4.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        dwell_n = dwell_q;
        cmd_n   = cmd_q;
        drop_n  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = P1;
                    cmd_n   = cmd;
                    dwell_n = (dwell == '0) ? DWELL_ONE : dwell;
                    cnt_n   = dwell_n - DWELL_ONE;
                end
            end
            P1, P2, P3, P4: begin
                drop_n = start;
                if (cnt_q == '0) begin
                    cnt_n = dwell_q - DWELL_ONE;
                    case (state_q)
                        P1:      state_n = P2;
                        P2:      state_n = P3;
                        P3:      state_n = P4;
                        default: begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end
                    endcase
                end else begin
                    cnt_n = cnt_q - DWELL_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // The last cycle of P4 is the one where the counter has reached zero.
        done_n  = (state_n == P4) && (cnt_n == '0);
        busy_n  = (state_n != IDLE);
        lines_n = busy_n ? phase_lines(cmd_n, state_n) : 2'b00;
        sent_n  = sent + SENT_W'(done_n);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dwell_q <= '0;
            cmd_q   <= 2'b00;
            outer   <= 1'b0;
            inner   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            drop    <= 1'b0;
            sent    <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            dwell_q <= dwell_n;
            cmd_q   <= cmd_n;
            outer   <= lines_n[1];
            inner   <= lines_n[0];
            busy    <= busy_n;
            done    <= done_n;
            drop    <= drop_n;
            sent    <= sent_n;
        end
    end

endmodule

// File: tb/tb_parking_sensor_emulator.sv
// Directed bench for parking_sensor_emulator. Each sampled cycle is packed as
// {outer, inner, busy, done, drop, sent} and compared against a scoreboard
// queue that is filled from the command table below.
module tb_parking_sensor_emulator;

    localparam int DWELL_W = 8;
    localparam int SENT_W  = 8;
    localparam int W       = 5 + SENT_W;

    logic               clk   = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [1:0]         cmd   = 2'b00;
    logic [DWELL_W-1:0] dwell = '0;
    logic               outer, inner, busy, done, drop;
    logic [SENT_W-1:0]  sent;

    int                checks     = 0;
    int                failures   = 0;
    logic [W-1:0]      exp_q[$];
    logic [SENT_W-1:0] sent_model = '0;
    logic [1:0]        pat[4][4];

    parking_sensor_emulator #(.DWELL_W(DWELL_W), .SENT_W(SENT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .cmd   (cmd),
        .dwell (dwell),
        .outer (outer),
        .inner (inner),
        .busy  (busy),
        .done  (done),
        .drop  (drop),
        .sent  (sent)
    );

    // Clock and sampling point: inputs change and outputs are read 1 time unit after the rising edge.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pack(input logic [1:0] lines, input logic b,
                                          input logic d, input logic dr,
                                          input logic [SENT_W-1:0] s);
        return {lines, b, d, dr, s};
    endfunction

    function automatic logic [W-1:0] dut_word();
        return {outer, inner, busy, done, drop, sent};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%b expected=<empty queue>", tag, dut_word());
        end else begin
            e = exp_q.pop_front();
            check(tag, dut_word(), e);
        end
    endtask

    // Runs one command. pulse_k > 0 raises start during cycle pulse_k.
    // abort_k > 0 applies reset at the end of cycle abort_k.
    // idle_after also checks the idle cycle that follows done.
    task automatic run_seq(input logic [1:0] c, input logic [DWELL_W-1:0] dw,
                           input int pulse_k, input int abort_k, input bit idle_after);
        int d;
        int n;
        int ph;
        bit dn;
        bit drp;
        d = (dw == 0) ? 1 : int'(dw);
        n = 4 * d;
        for (int k = 1; k <= n; k++) begin
            ph  = (k - 1) / d;
            dn  = (k == n);
            drp = (pulse_k > 0) && (k == pulse_k + 1);
            exp_q.push_back(pack(pat[c][ph], 1'b1, dn, drp,
                                 dn ? sent_model + 1'b1 : sent_model));
        end
        if (idle_after)
            exp_q.push_back(pack(2'b00, 1'b0, 1'b0, 1'b0, sent_model + 1'b1));

        cmd   = c;
        dwell = dw;
        start = 1'b1;
        for (int k = 1; k <= n; k++) begin
            tick();
            start = 1'b0;
            cmd   = 2'($urandom_range(0, 3));
            dwell = DWELL_W'($urandom_range(0, 255));
            pop_check($sformatf("cmd%0d_dw%0d_cyc%0d", c, dw, k));
            if (k == abort_k) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
                sent_model = '0;
                check("reset_mid_sequence", dut_word(), '0);
                exp_q.delete();
                return;
            end
            if (k == pulse_k) begin
                start = 1'b1;
                cmd   = 2'b00;
            end
        end
        sent_model = sent_model + 1'b1;
        if (idle_after) begin
            tick();
            pop_check($sformatf("cmd%0d_idle_after", c));
        end
    endtask

    initial begin
        pat[0][0] = 2'b10; pat[0][1] = 2'b11; pat[0][2] = 2'b01; pat[0][3] = 2'b00;
        pat[1][0] = 2'b01; pat[1][1] = 2'b11; pat[1][2] = 2'b10; pat[1][3] = 2'b00;
        pat[2][0] = 2'b10; pat[2][1] = 2'b00; pat[2][2] = 2'b01; pat[2][3] = 2'b00;
        pat[3][0] = 2'b01; pat[3][1] = 2'b00; pat[3][2] = 2'b10; pat[3][3] = 2'b00;

        // Reset held two cycles with random inputs.
        reset = 1'b0;
        start = 1'($urandom_range(0, 1));
        cmd   = 2'($urandom_range(0, 3));
        dwell = DWELL_W'($urandom_range(0, 255));
        tick();
        start = 1'($urandom_range(0, 1));
        tick();
        check("reset_state", dut_word(), '0);
        reset = 1'b1;
        start = 1'b0;
        tick();
        check("idle_no_start", dut_word(), '0);

        // Car enter, dwell 3.
        run_seq(2'b00, 8'd3, 0, 0, 1'b1);

        // Dwell 0 acts as 1, then back-to-back commands.
        run_seq(2'b11, 8'd0, 0, 0, 1'b1);
        run_seq(2'b01, 8'd0, 0, 0, 1'b1);
        run_seq(2'b10, 8'd0, 0, 0, 1'b1);

        // Start while busy is dropped.
        run_seq(2'b01, 8'd4, 2, 0, 1'b1);

        // Reset in the middle of P2, then a fresh command.
        run_seq(2'b00, 8'd5, 0, 7, 1'b0);
        run_seq(2'b00, 8'd3, 0, 0, 1'b1);

        // Counter wrap: 256 commands from a clean reset.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        sent_model = '0;
        check("reset_before_wrap", dut_word(), '0);
        for (int i = 0; i < 256; i++)
            run_seq(2'(i % 4), 8'd1, 0, 0, 1'b1);
        check("sent_wrap", W'(sent), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
